rgb_sequencer: RTL and testbench

Controller for the board's common-anode RGB LED. It selects one of eight fixed colours, either stepped manually by a debounced button or advanced automatically on a programmable dwell timer. It also PWM-dims all lit channels to a runtime brightness. It sits between the debounce instances and the LED_R/LED_G/LED_B pins and owns the colour index and the PWM timing.

---
 rtl/rgb_sequencer.sv | 113 +++++++++++
 tb/tb_rgb_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_sequencer.sv
// Eight-colour RGB LED sequencer: manual stepping or timed auto-advance,
// with PWM dimming of all lit channels. LED pins are active-low.
module rgb_sequencer #(
    parameter int unsigned DWELL_CYCLES = 12000000,
    parameter int unsigned PWM_BITS     = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                STEP,
    input  logic                MODE,
    input  logic [PWM_BITS-1:0] BRIGHT,
    output logic                LED_R,
    output logic                LED_G,
    output logic                LED_B,
    output logic [2:0]          COLOR_IDX,
    output logic                AUTO
);

    localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES);
    localparam logic [DWELL_W-1:0]  DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] DUTY_FULL  = '1;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_t;

    state_t              state;
    logic [DWELL_W-1:0]  dwell_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic                step_q;
    logic                mode_q;

    logic                step_rise;
    logic                mode_rise;
    logic                dwell_done;
    logic                pwm_on;
    logic [2:0]          rgb;

    assign step_rise  = STEP & ~step_q;
    assign mode_rise  = MODE & ~mode_q;
    assign dwell_done = (dwell_cnt == DWELL_LAST);
    // Full-scale duty forces always-on; otherwise on for the first `duty` counts.
    assign pwm_on     = (duty == DUTY_FULL) || (pwm_cnt < duty);
    assign AUTO       = (state == ST_AUTO);

    // Colour index to {R,G,B} lit pattern.
    always_comb begin
        rgb = 3'b000;
        case (COLOR_IDX)
            3'd0: rgb = 3'b000;
            3'd1: rgb = 3'b100;
            3'd2: rgb = 3'b010;
            3'd3: rgb = 3'b001;
            3'd4: rgb = 3'b110;
            3'd5: rgb = 3'b011;
            3'd6: rgb = 3'b101;
            3'd7: rgb = 3'b111;
            default: rgb = 3'b000;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= ST_MANUAL;
            COLOR_IDX <= 3'd0;
            dwell_cnt <= '0;
            pwm_cnt   <= '0;
            duty      <= '0;
            step_q    <= 1'b1;
            mode_q    <= 1'b1;
            LED_R     <= 1'b1;
            LED_G     <= 1'b1;
            LED_B     <= 1'b1;
        end else begin
            step_q  <= STEP;
            mode_q  <= MODE;
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (pwm_cnt == '0) begin
                duty <= BRIGHT;
            end
            LED_R <= ~(rgb[2] & pwm_on);
            LED_G <= ~(rgb[1] & pwm_on);
            LED_B <= ~(rgb[0] & pwm_on);

            if (state == ST_MANUAL) begin
                dwell_cnt <= '0;
                if (step_rise) begin
                    COLOR_IDX <= COLOR_IDX + 3'd1;
                end
                if (mode_rise) begin
                    state <= ST_AUTO;
                end
            end else begin
                // Leaving AUTO suppresses a coinciding dwell terminal; a step still counts.
                if (mode_rise) begin
                    state     <= ST_MANUAL;
                    dwell_cnt <= '0;
                    if (step_rise) begin
                        COLOR_IDX <= COLOR_IDX + 3'd1;
                    end
                end else if (step_rise || dwell_done) begin
                    COLOR_IDX <= COLOR_IDX + 3'd1;
                    dwell_cnt <= '0;
                end else begin
                    dwell_cnt <= dwell_cnt + DWELL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_sequencer.sv
// Directed bench for rgb_sequencer with a short dwell and a 4-bit PWM.
module tb_rgb_sequencer;

    localparam int unsigned DWELL = 4;
    localparam int unsigned PB    = 4;

    logic          CLK;
    logic          RST_N;
    logic          STEP;
    logic          MODE;
    logic [PB-1:0] BRIGHT;
    logic          LED_R;
    logic          LED_G;
    logic          LED_B;
    logic [2:0]    COLOR_IDX;
    logic          AUTO;

    int n_cmp;
    int n_fail;

    rgb_sequencer #(
        .DWELL_CYCLES(DWELL),
        .PWM_BITS    (PB)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .STEP     (STEP),
        .MODE     (MODE),
        .BRIGHT   (BRIGHT),
        .LED_R    (LED_R),
        .LED_G    (LED_G),
        .LED_B    (LED_B),
        .COLOR_IDX(COLOR_IDX),
        .AUTO     (AUTO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    // Reset for two edges; RST_N is released at a falling edge, no edge consumed after.
    task automatic do_reset(input logic step_level);
        RST_N = 1'b0;
        STEP  = step_level;
        MODE  = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        BRIGHT = 4'hF;
        do_reset(1'b0);
        n_cmp++;
        if ({COLOR_IDX, AUTO, LED_R, LED_G, LED_B} !== 7'b000_0_111) begin
            n_fail++;
            $display("FAIL reset_state: got idx=%0d auto=%0b rgb=%b required idx=0 auto=0 rgb=111",
                     COLOR_IDX, AUTO, {LED_R, LED_G, LED_B});
        end
    endtask

    task automatic test_manual_step();
        logic [2:0] exp_idx;
        tick();
        for (int i = 1; i <= 3; i++) begin
            STEP = 1'b1;
            tick();
            exp_idx = 3'(i);
            n_cmp++;
            if (COLOR_IDX !== exp_idx) begin
                n_fail++;
                $display("FAIL manual_step%0d: got idx=%0d required %0d", i, COLOR_IDX, exp_idx);
            end
            STEP = 1'b0;
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if ({LED_R, LED_G, LED_B, AUTO} !== 4'b110_0) begin
                n_fail++;
                $display("FAIL blue_full: cyc %0d got rgb=%b auto=%0b required rgb=110 auto=0",
                         i, {LED_R, LED_G, LED_B}, AUTO);
            end
        end
    endtask

    task automatic test_step_held_reset();
        do_reset(1'b1);
        tick();
        tick();
        tick();
        n_cmp++;
        if (COLOR_IDX !== 3'd0) begin
            n_fail++;
            $display("FAIL held_step: got idx=%0d required 0", COLOR_IDX);
        end
        STEP = 1'b0;
        tick();
        STEP = 1'b1;
        tick();
        n_cmp++;
        if (COLOR_IDX !== 3'd1) begin
            n_fail++;
            $display("FAIL fresh_step: got idx=%0d required 1", COLOR_IDX);
        end
        STEP = 1'b0;
        tick();
    endtask

    // Auto advance every DWELL cycles, wrap, and a step landing on a terminal cycle.
    task automatic test_auto();
        logic [2:0] exp_idx;
        do_reset(1'b0);
        tick();
        MODE = 1'b1;
        tick();
        MODE = 1'b0;
        n_cmp++;
        if ({AUTO, COLOR_IDX} !== 4'b1_000) begin
            n_fail++;
            $display("FAIL enter_auto: got auto=%0b idx=%0d required auto=1 idx=0", AUTO, COLOR_IDX);
        end
        for (int k = 1; k <= 44; k++) begin
            tick();
            exp_idx = 3'((k / 4) % 8);
            n_cmp++;
            if (COLOR_IDX !== exp_idx) begin
                n_fail++;
                $display("FAIL auto_adv k=%0d: got idx=%0d required %0d", k, COLOR_IDX, exp_idx);
            end
            STEP = (k == 39);
        end
        MODE = 1'b1;
        tick();
        MODE = 1'b0;
        n_cmp++;
        if ({AUTO, COLOR_IDX} !== 4'b0_011) begin
            n_fail++;
            $display("FAIL leave_auto: got auto=%0b idx=%0d required auto=0 idx=3", AUTO, COLOR_IDX);
        end
        for (int i = 0; i < 6; i++) tick();
        n_cmp++;
        if (COLOR_IDX !== 3'd3) begin
            n_fail++;
            $display("FAIL manual_hold: got idx=%0d required 3", COLOR_IDX);
        end
    endtask

    task automatic test_simultaneous();
        MODE = 1'b1;
        STEP = 1'b1;
        tick();
        MODE = 1'b0;
        STEP = 1'b0;
        n_cmp++;
        if ({AUTO, COLOR_IDX} !== 4'b1_100) begin
            n_fail++;
            $display("FAIL mode_step_same: got auto=%0b idx=%0d required auto=1 idx=4", AUTO, COLOR_IDX);
        end
        tick();
        tick();
        tick();
        MODE = 1'b1;
        tick();
        MODE = 1'b0;
        n_cmp++;
        if ({AUTO, COLOR_IDX} !== 4'b0_100) begin
            n_fail++;
            $display("FAIL mode_on_terminal: got auto=%0b idx=%0d required auto=0 idx=4", AUTO, COLOR_IDX);
        end
    endtask

    task automatic test_pwm_levels();
        logic [PB-1:0] levels [3];
        int            exp_low [3];
        int            low_r;
        int            bad_gb;
        levels  = '{4'd4, 4'd0, 4'd15};
        exp_low = '{8, 0, 32};
        do_reset(1'b0);
        tick();
        STEP = 1'b1;
        tick();
        STEP = 1'b0;
        for (int j = 0; j < 3; j++) begin
            BRIGHT = levels[j];
            for (int i = 0; i < 34; i++) tick();
            low_r  = 0;
            bad_gb = 0;
            for (int i = 0; i < 32; i++) begin
                tick();
                if (LED_R === 1'b0) low_r++;
                if ({LED_G, LED_B} !== 2'b11) bad_gb++;
            end
            n_cmp++;
            if (low_r !== exp_low[j]) begin
                n_fail++;
                $display("FAIL pwm_red bright=%0d: got %0d low of 32 required %0d", levels[j], low_r, exp_low[j]);
            end
            n_cmp++;
            if (bad_gb !== 0) begin
                n_fail++;
                $display("FAIL pwm_gb bright=%0d: got %0d lit cycles required 0", levels[j], bad_gb);
            end
        end
    endtask

    // Duty change at counter 7 only takes hold after the wrap.
    task automatic test_bright_midperiod();
        int   low_new;
        logic exp_r;
        BRIGHT = 4'd4;
        do_reset(1'b0);
        low_new = 0;
        for (int k = 0; k <= 32; k++) begin
            tick();
            STEP = (k == 0);
            if (k == 6) BRIGHT = 4'd12;
            if (k == 2) begin
                n_cmp++;
                if (COLOR_IDX !== 3'd1) begin
                    n_fail++;
                    $display("FAIL bright_idx: got idx=%0d required 1", COLOR_IDX);
                end
            end
            if (k >= 2) begin
                exp_r = (k <= 16) ? !((k % 16) < 4) : !((k % 16) < 12);
                n_cmp++;
                if (LED_R !== exp_r) begin
                    n_fail++;
                    $display("FAIL bright_mid k=%0d: got LED_R=%0b required %0b", k, LED_R, exp_r);
                end
                if (k >= 17 && LED_R === 1'b0) low_new++;
            end
        end
        n_cmp++;
        if (low_new !== 12) begin
            n_fail++;
            $display("FAIL bright_new_period: got %0d on-cycles required 12", low_new);
        end
    endtask

    task automatic test_reset_mid_auto();
        logic [2:0] exp_idx;
        BRIGHT = 4'hF;
        do_reset(1'b0);
        tick();
        MODE = 1'b1;
        tick();
        MODE = 1'b0;
        for (int k = 1; k <= 21; k++) tick();
        n_cmp++;
        if ({AUTO, COLOR_IDX} !== 4'b1_101) begin
            n_fail++;
            $display("FAIL pre_reset: got auto=%0b idx=%0d required auto=1 idx=5", AUTO, COLOR_IDX);
        end
        RST_N = 1'b0;
        tick();
        n_cmp++;
        if ({COLOR_IDX, AUTO, LED_R, LED_G, LED_B} !== 7'b000_0_111) begin
            n_fail++;
            $display("FAIL mid_reset: got idx=%0d auto=%0b rgb=%b required idx=0 auto=0 rgb=111",
                     COLOR_IDX, AUTO, {LED_R, LED_G, LED_B});
        end
        RST_N = 1'b1;
        tick();
        MODE = 1'b1;
        tick();
        MODE = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_idx = (k == 4) ? 3'd1 : 3'd0;
            n_cmp++;
            if (COLOR_IDX !== exp_idx) begin
                n_fail++;
                $display("FAIL post_reset_dwell k=%0d: got idx=%0d required %0d", k, COLOR_IDX, exp_idx);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        RST_N  = 1'b0;
        STEP   = 1'b0;
        MODE   = 1'b0;
        BRIGHT = 4'hF;
        test_reset();
        test_manual_step();
        test_step_held_reset();
        test_auto();
        test_simultaneous();
        test_pwm_levels();
        test_bright_midperiod();
        test_reset_mid_auto();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
